fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program-counter unit.
- Issues one instruction-memory request per current PC and tells the PC unit when to advance.
- Holds fetched {pc, instr} pairs in an in-order DEPTH-entry queue and presents them to decode with a valid/ready handshake.
- On a taken branch (flush), discards queued entries and in-flight responses so decode never sees wrong-path instructions.

Parameters:
- ADDRESS_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 4, queue entries; power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- fetch_pc  input  ADDRESS_WIDTH  current PC from the PC unit.
- pc_advance  output  1  PC unit loads its next PC this edge; equals request fire.
- flush  input  1  taken branch or redirect; discard all queued and in-flight fetches.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  ADDRESS_WIDTH  request address; equals fetch_pc.
- imem_resp_valid  input  1  response data valid; in order, ≥1 cycle after its request, never back-pressured.
- imem_resp_data  input  DATA_WIDTH  fetched instruction.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode accepts head.
- out_pc  output  ADDRESS_WIDTH  PC of head entry.
- out_instr  output  DATA_WIDTH  instruction of head entry.

Behaviour:
- Storage:
  - Circular buffer of DEPTH slots, each holding pc, instr and a filled flag.
  - Pointers alloc_ptr, fill_ptr and head_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - occ (0..DEPTH) counts allocated slots.
  - drop_cnt (0..2*DEPTH) counts stale responses still to be discarded.
- Reset (rst=0, async): all pointers, occ and drop_cnt cleared; all filled flags cleared. Outputs: out_valid=0, imem_req_valid=0, pc_advance=0.
- Request:
  - imem_req_valid = (occ<DEPTH) && !flush, using the registered occ.
  - A dequeue in the same cycle does not free a slot for that cycle's request.
  - Fire = imem_req_valid && imem_req_ready.
  - On fire: slot[alloc_ptr] gets pc=fetch_pc and filled=0; alloc_ptr++; occ++.
  - pc_advance = fire. The PC holds whenever there is no fire.
- Response:
  - On imem_resp_valid with drop_cnt>0: data discarded, drop_cnt--.
  - Otherwise: slot[fill_ptr] gets instr=imem_resp_data and filled=1; fill_ptr++.
- Output:
  - out_valid = slot[head_ptr].filled && (occ>0) && !flush.
  - out_pc and out_instr are driven combinationally from slot[head_ptr].
  - Dequeue = out_valid && out_ready: slot filled cleared, head_ptr++, occ--.
  - Minimum latency is 2 cycles: request fire at cycle N, response at N+1, out_valid at N+2. There is no bypass.
- Simultaneous events (no flush): fire, response and dequeue may all occur in one cycle. occ changes by +fire −dequeue.
- Flush cycle:
  - No request and no dequeue.
  - All allocated slots are invalidated: occ=0, filled flags cleared, alloc_ptr=fill_ptr=head_ptr.
  - drop_cnt_next = drop_cnt + (number of allocated-but-unfilled slots) − imem_resp_valid.
  - The response arriving in the flush cycle is always stale and is consumed by the subtraction above.
  - Fetch resumes the next cycle from the redirected fetch_pc.
- Flush during drop: stale counts accumulate. Total in flight is bounded by 2*DEPTH.
- Requests may issue while drop_cnt>0. Responses are in order, so the first drop_cnt responses are discarded and later ones fill slots.
- Mid-operation reset: immediately returns to the reset state. Responses arriving after reset release are treated as normal fills; the system requirement is that imem is reset together with this block.
- Assertions:
  - No response when drop_cnt == 0 and there are no unfilled allocated slots.
  - occ never exceeds DEPTH.

Test Plan:
- Reset, imem always ready, 1-cycle response, out_ready=1, fetch_pc 0x0,0x4,0x8,… → pc_advance=1 every cycle; out_pc 0x0 at cycle 2, then one instruction per cycle in order.
- out_ready=0 with 1-cycle memory → after 4 fires occ=4 and imem_req_valid=0; set out_ready=1 → 0x0,0x4,0x8,0xC dequeued in order, requesting resumes.
- Memory latency 3 cycles, imem_req_ready toggling 1/0 → every accepted address appears once, in order, with matching instr; no duplicates.
- Two requests in flight (0x10, 0x14), flush with no response that cycle, fetch_pc redirects to 0x100 → drop_cnt=2; the next two responses are discarded; out_pc first shows 0x100.
- Flush in the same cycle as a response and a dequeue attempt, with one slot filled and one unfilled → no dequeue; drop_cnt=0 afterwards (1 unfilled − 1 response); queue empty.
- Assert rst mid-stream with occ=3 → out_valid, imem_req_valid and pc_advance drop to 0 asynchronously; after release, first out_pc equals the first post-reset fetch_pc.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, the PC unit, instruction memory
// and decode.
//   master : the fetch queue (drives requests, pc_advance and the decode side)
//   slave  : the environment (PC unit, imem, decode)
interface fetch_queue_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic                     pc_advance;
    logic                     flush;
    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [ADDRESS_WIDTH-1:0] imem_req_addr;
    logic                     imem_resp_valid;
    logic [DATA_WIDTH-1:0]    imem_resp_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDRESS_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0]    out_instr;

    modport master (
        input  fetch_pc, flush, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
        output pc_advance, imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        output fetch_pc, flush, imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
        input  pc_advance, imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch queue sitting after the PC unit.
// Issues one imem request per PC, tells the PC unit to advance on each
// accepted request, keeps {pc, instr} pairs in an in-order circular buffer
// and hands them to decode over valid/ready. A flush drops everything queued
// and counts the responses still in flight so they are discarded on arrival.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : fetch_queue_if.master (PC unit, imem request/response, decode)
module fetch_queue #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int DCW = $clog2(2 * DEPTH + 1);

    logic [ADDRESS_WIDTH-1:0] pc_q    [DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_d    [DEPTH];
    logic [DATA_WIDTH-1:0]    instr_q [DEPTH];
    logic [DATA_WIDTH-1:0]    instr_d [DEPTH];
    logic [DEPTH-1:0]         filled_q, filled_d;
    logic [PW-1:0]            alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0]            fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]            head_ptr_q, head_ptr_d;
    logic [CW-1:0]            occ_q, occ_d;
    logic [DCW-1:0]           drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]            filled_cnt;
    logic [CW-1:0]            unfilled_cnt;
    logic                     fire;
    logic                     deq;

    // Filled flags are only ever set on allocated slots, so the allocated
    // but still-unfilled count is occupancy minus the filled population.
    always_comb begin
        filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + CW'(filled_q[i]);
        end
        unfilled_cnt = occ_q - filled_cnt;
    end

    // Registered occ only: a same-cycle dequeue does not open a slot.
    assign bus.imem_req_valid = rst && (occ_q < CW'(DEPTH)) && !bus.flush;
    assign bus.imem_req_addr  = bus.fetch_pc;
    assign fire               = bus.imem_req_valid && bus.imem_req_ready;
    assign bus.pc_advance     = fire;

    assign bus.out_valid = rst && filled_q[head_ptr_q] && (occ_q != '0) && !bus.flush;
    assign bus.out_pc    = pc_q[head_ptr_q];
    assign bus.out_instr = instr_q[head_ptr_q];
    assign deq           = bus.out_valid && bus.out_ready;

    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        filled_d    = filled_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        occ_d       = occ_q;
        drop_cnt_d  = drop_cnt_q;

        if (bus.flush) begin
            // Every unfilled slot still has a response coming; the one
            // arriving this cycle (if any) is already stale.
            occ_d      = '0;
            filled_d   = '0;
            fill_ptr_d = alloc_ptr_q;
            head_ptr_d = alloc_ptr_q;
            drop_cnt_d = drop_cnt_q + DCW'(unfilled_cnt) - DCW'(bus.imem_resp_valid);
        end else begin
            // Head, fill and alloc slots are always distinct when active.
            if (deq) begin
                filled_d[head_ptr_q] = 1'b0;
                head_ptr_d           = head_ptr_q + PW'(1);
            end
            if (bus.imem_resp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - DCW'(1);
                end else begin
                    instr_d[fill_ptr_q]  = bus.imem_resp_data;
                    filled_d[fill_ptr_q] = 1'b1;
                    fill_ptr_d           = fill_ptr_q + PW'(1);
                end
            end
            if (fire) begin
                pc_d[alloc_ptr_q]     = bus.fetch_pc;
                filled_d[alloc_ptr_q] = 1'b0;
                alloc_ptr_d           = alloc_ptr_q + PW'(1);
            end
            occ_d = occ_q + CW'(fire) - CW'(deq);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            occ_q       <= '0;
            drop_cnt_q  <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            filled_q    <= filled_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            occ_q       <= occ_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    a_occ_bound: assert property (@(posedge clk) disable iff (!rst)
        occ_q <= CW'(DEPTH));

    a_resp_expected: assert property (@(posedge clk) disable iff (!rst)
        bus.imem_resp_valid |-> (drop_cnt_q != '0 || unfilled_cnt != '0));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a PC-unit/imem model drives the bus, each
// test pushes its hand-computed PC sequence into a scoreboard, and a
// negedge monitor pops and compares every dequeued {pc, instr}.
module tb_fetch_queue;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fetch_queue #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;

    logic [AW-1:0] mem_addr_q [$];
    int            mem_due_q  [$];
    logic [AW-1:0] exp_pc_q   [$];
    logic [AW-1:0] mon_e;

    // Memory image: instruction word derived from its address.
    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
        return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual_pc=%0h required=none", bus.out_pc);
            end else begin
                mon_e = exp_pc_q.pop_front();
                chk("out_pc", bus.out_pc, mon_e);
                chk("out_instr", bus.out_instr, instr_of(mon_e));
            end
        end
    end

    // One clock: sample at negedge, then advance the PC unit and imem models.
    task automatic tick();
        logic          f;
        logic [AW-1:0] a;
        @(negedge clk);
        f = bus.imem_req_valid && bus.imem_req_ready;
        a = bus.imem_req_addr;
        chk("pc_advance", bus.pc_advance, f);
        if (bus.imem_req_valid) chk("req_addr", a, bus.fetch_pc);
        @(posedge clk);
        #1;
        if (f) begin
            mem_addr_q.push_back(a);
            mem_due_q.push_back(cyc + lat);
            bus.fetch_pc = bus.fetch_pc + 32'd4;
        end
        cyc++;
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = instr_of(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
        end
    endtask

    task automatic drain(input string tname);
        bus.imem_req_ready = 1'b0;
        bus.out_ready      = 1'b1;
        bus.flush          = 1'b0;
        repeat (10) tick();
        chk({tname, "_drained"}, exp_pc_q.size(), 0);
        #1;
        chk({tname, "_idle"}, bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_pc        = '0;
        bus.flush           = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.out_ready       = 1'b1;

        // Reset state, with ready inputs high so the gating is visible.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_pc_advance", bus.pc_advance, 0);
        rst = 1'b1;

        // T1: streaming, 1-cycle memory, first output two cycles after fire.
        for (int k = 0; k < 8; k++) exp_pc_q.push_back(AW'(4 * k));
        bus.fetch_pc = 32'h0; lat = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t1_req_valid", bus.imem_req_valid, 1);
            if (i < 2) chk("t1_early_out_valid", bus.out_valid, 0);
            if (i == 2) begin
                chk("t1_first_out_valid", bus.out_valid, 1);
                chk("t1_first_out_pc", bus.out_pc, 32'h0);
            end
            tick();
        end
        drain("t1");

        // T2: decode stalled until the queue is full, then released.
        for (int k = 0; k < 5; k++) exp_pc_q.push_back(AW'(4 * k));
        bus.fetch_pc = 32'h0; lat = 1;
        bus.imem_req_ready = 1'b1; bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1; chk("t2_fill_req_valid", bus.imem_req_valid, 1);
            tick();
        end
        #1;
        chk("t2_full_req_valid", bus.imem_req_valid, 0);
        chk("t2_full_out_valid", bus.out_valid, 1);
        chk("t2_full_out_pc", bus.out_pc, 32'h0);
        tick();
        bus.out_ready = 1'b1;
        #1; chk("t2_deq_req_valid", bus.imem_req_valid, 0);
        tick();
        #1; chk("t2_resume_req_valid", bus.imem_req_valid, 1);
        tick();
        drain("t2");

        // T3: 3-cycle memory, request ready toggling.
        for (int k = 0; k < 6; k++) exp_pc_q.push_back(32'h200 + AW'(4 * k));
        bus.fetch_pc = 32'h200; lat = 3; bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.imem_req_ready = (i % 2 == 0);
            if (i % 2 == 0) begin
                #1; chk("t3_req_valid", bus.imem_req_valid, 1);
            end
            tick();
        end
        drain("t3");

        // T4: flush with two requests in flight and no response that cycle.
        exp_pc_q.push_back(32'h100);
        exp_pc_q.push_back(32'h104);
        bus.fetch_pc = 32'h10; lat = 3; bus.out_ready = 1'b1; bus.imem_req_ready = 1'b1;
        tick();
        tick();
        bus.flush = 1'b1;
        #1;
        chk("t4_flush_req_valid", bus.imem_req_valid, 0);
        chk("t4_flush_out_valid", bus.out_valid, 0);
        tick();
        bus.flush = 1'b0; bus.fetch_pc = 32'h100;
        #1; chk("t4_drop0_out_valid", bus.out_valid, 0);
        tick();
        #1; chk("t4_drop1_out_valid", bus.out_valid, 0);
        tick();
        bus.imem_req_ready = 1'b0;
        #1; chk("t4_wait_out_valid", bus.out_valid, 0);
        tick();
        drain("t4");

        // T5: flush with one filled + one unfilled slot, response and
        // dequeue attempt in the same cycle.
        bus.fetch_pc = 32'h20; lat = 2; bus.out_ready = 1'b0; bus.imem_req_ready = 1'b1;
        tick();
        tick();
        bus.imem_req_ready = 1'b0;
        #1; chk("t5_pre_out_valid", bus.out_valid, 0);
        tick();
        #1; chk("t5_head_filled", bus.out_valid, 1);
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk("t5_flush_out_valid", bus.out_valid, 0);
        chk("t5_flush_req_valid", bus.imem_req_valid, 0);
        tick();
        bus.flush = 1'b0; bus.fetch_pc = 32'h300;
        #1; chk("t5_empty_out_valid", bus.out_valid, 0);
        exp_pc_q.push_back(32'h300);
        bus.imem_req_ready = 1'b1;
        tick();
        drain("t5");

        // T6: asynchronous reset mid-stream with occ=3.
        bus.fetch_pc = 32'h40; lat = 1; bus.out_ready = 1'b0; bus.imem_req_ready = 1'b1;
        repeat (3) tick();
        #1;
        chk("t6_pre_out_valid", bus.out_valid, 1);
        chk("t6_pre_req_valid", bus.imem_req_valid, 1);
        chk("t6_pre_pc_advance", bus.pc_advance, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_req_valid", bus.imem_req_valid, 0);
        chk("t6_rst_pc_advance", bus.pc_advance, 0);
        mem_addr_q.delete();
        mem_due_q.delete();
        exp_pc_q.delete();
        bus.imem_resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.fetch_pc = 32'h400; bus.out_ready = 1'b1; bus.imem_req_ready = 1'b1;
        exp_pc_q.push_back(32'h400);
        exp_pc_q.push_back(32'h404);
        tick();
        tick();
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
